// File: rtl/msdf_otf_converter.sv
// msdf_otf_converter
// On-the-fly conversion of an MSDF radix-2 signed-digit stream (N digits,
// most significant first) into an (N+1)-bit two's-complement fraction using
// the Ercegovac-Lang Q/QM register pair. The digit window is located by
// counting DELAY cycles from the io_start pulse shared with the upstream adder.
// Optional build macro: MSDF_OTF_DIGIT_CHECK_EN (sticky flag on digit 2'b11).
module msdf_otf_converter #(
   parameter int N     = 8,
   parameter int DELAY = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         io_start,
   input  logic [1:0]   io_digit,
   output logic [N:0]   io_result,
   output logic         io_done,
   output logic         io_busy,
   output logic         io_err
);

   localparam int DW = (N > 1) ? $clog2(N) : 1;
   localparam int WW = (DELAY > 2) ? $clog2(DELAY - 1) : 1;
   localparam logic [DW-1:0] DIG_LAST  = DW'(N - 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'((DELAY > 1) ? DELAY - 2 : 0);

   typedef enum logic [1:0] {IDLE, WAIT, CONV, DONE} state_t;

   state_t          state_reg;
   logic [DW-1:0]   dig_cnt_reg;
   logic [WW-1:0]   wait_cnt_reg;
   // The top bit of the N+1-bit Q/QM is always shifted out before it is ever
   // read, so only the low N bits are held; the appended bit restores width.
   logic [N-1:0]    q_reg;
   logic [N-1:0]    qm_reg;
   logic [N:0]      q_step;
   logic [N:0]      qm_step;

   // Next Q/QM for the digit on io_digit; 2'b00 and 2'b11 both act as zero.
   always_comb begin
      q_step  = {q_reg, 1'b0};
      qm_step = {qm_reg, 1'b1};
      if (io_digit == 2'b10) begin
         q_step  = {q_reg, 1'b1};
         qm_step = {q_reg, 1'b0};
      end else if (io_digit == 2'b01) begin
         q_step  = {qm_reg, 1'b1};
         qm_step = {qm_reg, 1'b0};
      end
   end

   // Control FSM with registered outputs. io_start wins over everything, so a
   // start arriving on the last digit cycle aborts instead of publishing.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= IDLE;
         dig_cnt_reg  <= '0;
         wait_cnt_reg <= '0;
         q_reg        <= '0;
         qm_reg       <= '1;
         io_result    <= '0;
         io_done      <= 1'b0;
         io_busy      <= 1'b0;
      end else begin
         io_done <= 1'b0;
         if (io_start) begin
            q_reg        <= '0;
            qm_reg       <= '1;
            dig_cnt_reg  <= '0;
            wait_cnt_reg <= '0;
            io_busy      <= 1'b1;
            state_reg    <= (DELAY == 1) ? CONV : WAIT;
         end else begin
            case (state_reg)
               IDLE: begin
                  state_reg <= IDLE;
               end
               WAIT: begin
                  if (wait_cnt_reg == WAIT_LAST) begin
                     state_reg <= CONV;
                  end else begin
                     wait_cnt_reg <= wait_cnt_reg + 1'b1;
                  end
               end
               CONV: begin
                  q_reg  <= q_step[N-1:0];
                  qm_reg <= qm_step[N-1:0];
                  if (dig_cnt_reg == DIG_LAST) begin
                     // Last digit: the converted value goes straight out, so
                     // io_result and io_done are visible in the DONE cycle.
                     io_result   <= q_step;
                     io_done     <= 1'b1;
                     io_busy     <= 1'b0;
                     dig_cnt_reg <= '0;
                     state_reg   <= DONE;
                  end else begin
                     dig_cnt_reg <= dig_cnt_reg + 1'b1;
                  end
               end
               DONE: begin
                  state_reg <= IDLE;
               end
               default: begin
                  state_reg <= IDLE;
               end
            endcase
         end
      end
   end

`ifdef MSDF_OTF_DIGIT_CHECK_EN
   logic err_reg;

   // Sticky flag for a non-canonical 2'b11 digit; only a new start clears it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_reg <= 1'b0;
      end else if (io_start) begin
         err_reg <= 1'b0;
      end else if (state_reg == CONV && io_digit == 2'b11) begin
         err_reg <= 1'b1;
      end
   end

   assign io_err = err_reg;
`else
   assign io_err = 1'b0;
`endif

endmodule
